// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic echo responder.
// Timing defaults assume a 50 MHz clock.
package ultrasonic_pkg;

    localparam int DEF_CNT_W          = 22;
    localparam int DEF_TRIG_MIN       = 500;
    localparam int DEF_BURST          = 10000;
    localparam int DEF_CYCLES_PER_CM  = 2900;
    localparam int DEF_MAX_CM         = 400;
    localparam int DEF_TIMEOUT        = 1900000;
    localparam int DEF_HOLDOFF        = 500000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_HI,
        ST_BURST,
        ST_ECHO,
        ST_HOLDOFF
    } state_t;

endpackage

// File: rtl/ultrasonic_echo_responder_trig_sync.sv
// Two-flop synchronizer for the asynchronous trig pin, with rise/fall
// detection against the previous synchronized value.
module trig_sync (
    input  logic clock,
    input  logic reset,
    input  logic trig,
    output logic trig_s,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= trig;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign trig_s = s2;
    assign rise   = s2 & ~prev;
    assign fall   = ~s2 & prev;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style responder: qualifies trig, waits a burst delay, then
// drives an echo pulse whose width encodes the latched distance.
module ultrasonic_echo_responder
    import ultrasonic_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int TRIG_MIN_CYCLES = DEF_TRIG_MIN,
    parameter int BURST_CYCLES    = DEF_BURST,
    parameter int CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
    parameter int MAX_CM          = DEF_MAX_CM,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_reject,
    output logic       meas_done
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_MIN_C = CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CPC_C      = CNT_W'(CYCLES_PER_CM);

    logic             trig_s;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [8:0]       dist_q;
    logic [8:0]       dist_n;
    logic [CNT_W-1:0] echo_w;
    logic             reject_n;
    logic             done_n;

    trig_sync u_trig_sync (
        .clock  (clock),
        .reset  (reset),
        .trig   (trig),
        .trig_s (trig_s),
        .rise   (rise),
        .fall   (fall)
    );

    // Zero or out-of-range distance reports "no object" via the timeout width.
    always_comb begin
        if (dist_q == 9'd0 || int'(dist_q) > MAX_CM)
            echo_w = TIMEOUT_C;
        else
            echo_w = CNT_W'(dist_q) * CPC_C;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dist_q      <= '0;
            echo        <= 1'b0;
            busy        <= 1'b0;
            trig_reject <= 1'b0;
            meas_done   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dist_q      <= dist_n;
            echo        <= (state_n == ST_ECHO);
            busy        <= (state_n != ST_IDLE);
            trig_reject <= reject_n;
            meas_done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dist_n   = dist_q;
        reject_n = 1'b0;
        done_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_TRIG_HI;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_TRIG_HI: begin
                if (fall) begin
                    cnt_n = '0;
                    if (cnt >= TRIG_MIN_C) begin
                        state_n = ST_BURST;
                        dist_n  = distance_cm;
                    end else begin
                        state_n  = ST_IDLE;
                        reject_n = 1'b1;
                    end
                end else if (trig_s && cnt != '1) begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_BURST: begin
                reject_n = rise;
                if (cnt == BURST_LAST) begin
                    state_n = ST_ECHO;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_ECHO: begin
                reject_n = rise;
                if (cnt == echo_w - CNT_ONE) begin
                    state_n = ST_HOLDOFF;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                reject_n = rise;
                if (cnt == HOLD_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder using small timing parameters
// (TRIG_MIN=5, BURST=4, CPC=3, MAX_CM=10, TIMEOUT=50, HOLDOFF=8).
module tb_ultrasonic_echo_responder;

    logic       clock;
    logic       reset;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       trig_reject;
    logic       meas_done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int rej_cnt  = 0;
    int done_cnt = 0;
    int cur_w    = 0;
    int last_w   = 0;

    ultrasonic_echo_responder #(
        .CNT_W           (22),
        .TRIG_MIN_CYCLES (5),
        .BURST_CYCLES    (4),
        .CYCLES_PER_CM   (3),
        .MAX_CM          (10),
        .TIMEOUT_CYCLES  (50),
        .HOLDOFF_CYCLES  (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .trig_reject (trig_reject),
        .meas_done   (meas_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters and echo width measured on the falling edge.
    always @(negedge clock) begin
        if (trig_reject) rej_cnt++;
        if (meas_done) done_cnt++;
        if (echo) cur_w++;
        else if (cur_w != 0) begin
            last_w = cur_w;
            cur_w  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_trig(input int n);
        @(negedge clock);
        trig = 1'b1;
        repeat (n) @(negedge clock);
        trig = 1'b0;
    endtask

    task automatic wait_echo(input string tag);
        int n = 0;
        while (!echo && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(echo), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int lat;
        int w;
        int hold;
        int rej0;
        int done0;

        reset       = 1'b1;
        trig        = 1'b0;
        distance_cm = 9'd0;
        repeat (3) @(negedge clock);
        check("rst_echo", 32'(echo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reject", 32'(trig_reject), 32'd0);
        check("rst_done", 32'(meas_done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Valid measurement: 7 cm -> 21 cycles, latency 7, busy drops 8 later.
        distance_cm = 9'd7;
        done0 = done_cnt;
        do_trig(6);
        lat = 0;
        while (!echo && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("valid_latency", 32'(lat), 32'd7);
        w = 0;
        while (echo && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("valid_width", 32'(w), 32'd21);
        check("valid_done_pulse", 32'(meas_done), 32'd1);
        hold = 0;
        while (busy && hold < 100) begin
            @(negedge clock);
            hold++;
        end
        check("valid_holdoff", 32'(hold), 32'd8);
        repeat (2) @(negedge clock);
        check("valid_done_count", 32'(done_cnt - done0), 32'd1);

        // Short trigger is rejected.
        rej0 = rej_cnt;
        w = last_w;
        do_trig(3);
        repeat (10) @(negedge clock);
        check("short_reject", 32'(rej_cnt - rej0), 32'd1);
        check("short_echo", 32'(echo), 32'd0);
        check("short_no_pulse", 32'(last_w), 32'(w));
        check("short_busy", 32'(busy), 32'd0);

        // No object and the MAX_CM boundary (trig exactly TRIG_MIN cycles).
        distance_cm = 9'd0;
        do_trig(6);
        wait_idle("zero_idle");
        check("zero_width", 32'(last_w), 32'd50);
        distance_cm = 9'd11;
        do_trig(6);
        wait_idle("over_idle");
        check("over_width", 32'(last_w), 32'd50);
        distance_cm = 9'd10;
        do_trig(5);
        wait_idle("max_idle");
        check("max_width", 32'(last_w), 32'd30);

        // Retrigger during ECHO and during HOLDOFF.
        distance_cm = 9'd7;
        rej0 = rej_cnt;
        do_trig(6);
        wait_echo("retrig_echo_seen");
        repeat (3) @(negedge clock);
        do_trig(2);
        while (echo) @(negedge clock);
        repeat (2) @(negedge clock);
        trig = 1'b1;
        repeat (2) @(negedge clock);
        trig = 1'b0;
        wait_idle("retrig_idle");
        check("retrig_rejects", 32'(rej_cnt - rej0), 32'd2);
        check("retrig_width", 32'(last_w), 32'd21);
        do_trig(6);
        wait_idle("retrig_next_idle");
        check("retrig_next_width", 32'(last_w), 32'd21);
        check("retrig_next_rejects", 32'(rej_cnt - rej0), 32'd2);

        // Distance changed during BURST does not affect this measurement.
        distance_cm = 9'd7;
        do_trig(6);
        repeat (3) @(negedge clock);
        distance_cm = 9'd2;
        wait_idle("latch_idle");
        check("latch_width", 32'(last_w), 32'd21);
        do_trig(6);
        wait_idle("latch_next_idle");
        check("latch_next_width", 32'(last_w), 32'd6);

        // Asynchronous reset mid-ECHO.
        distance_cm = 9'd7;
        do_trig(6);
        wait_echo("rstmid_echo_seen");
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rstmid_echo", 32'(echo), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        distance_cm = 9'd3;
        repeat (2) @(negedge clock);
        do_trig(6);
        wait_idle("rstmid_after_idle");
        check("rstmid_after_width", 32'(last_w), 32'd9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
